// File: rtl/my_pkg.sv
// rtl/my_pkg.sv - shared types for the adder unit and its request arbiter
package my_pkg;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    OP1 = 2'd1,
    OP2 = 2'd2,
    OP3 = 2'd3
  } instruction_type;

  localparam int ADDER_LAT     = 1;
  localparam int ARB_NREQ_MAX  = 4;
  localparam int ARB_TAG_W_MAX = 8;

  typedef struct packed {
    logic [31:0]              opA;
    logic [31:0]              opB;
    instruction_type          op;
    logic [ARB_TAG_W_MAX-1:0] tag;
  } arb_req_t;

endpackage

// File: rtl/adder_arbiter_rr.sv
// rtl/adder_arbiter_rr.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         eligible,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int IW = $clog2(N);

  // Scan offsets from far to near so the nearest eligible slot after ptr wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N;
      if (eligible[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - shares one registered adder among NREQ requesters,
// returning each tagged result through a 1-entry per-requester buffer
module adder_arbiter
  import my_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int TAG_W = 4
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic            [NREQ-1:0]       req_valid,
  output logic            [NREQ-1:0]       req_ready,
  input  logic            [NREQ-1:0][31:0] req_opA,
  input  logic            [NREQ-1:0][31:0] req_opB,
  input  instruction_type [NREQ-1:0]       req_op,
  input  logic [NREQ-1:0][TAG_W-1:0]       req_tag,
  output logic            [31:0]           add_opA,
  output logic            [31:0]           add_opB,
  output instruction_type                  add_i,
  input  logic            [31:0]           add_result,
  output logic            [NREQ-1:0]       rsp_valid,
  input  logic            [NREQ-1:0]       rsp_ready,
  output logic            [NREQ-1:0][31:0] rsp_data,
  output logic [NREQ-1:0][TAG_W-1:0]       rsp_tag
);

  localparam int IW = $clog2(NREQ);

  arb_req_t [NREQ-1:0] reqs;
  arb_req_t            sel;
  logic [NREQ-1:0]     eligible;
  logic [NREQ-1:0]     grant;
  logic [IW-1:0]       gidx;
  logic [IW-1:0]       ptr;
  logic                unused_tag_bits;

  // In-flight tracking, one stage per cycle of adder latency.
  logic [ADDER_LAT-1:0]            fl_v;
  logic [ADDER_LAT-1:0][IW-1:0]    fl_id;
  logic [ADDER_LAT-1:0][TAG_W-1:0] fl_tag;

  logic [31:0]     hold_opA;
  logic [31:0]     hold_opB;
  instruction_type hold_op;

  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      reqs[k].opA = req_opA[k];
      reqs[k].opB = req_opB[k];
      reqs[k].op  = req_op[k];
      reqs[k].tag = ARB_TAG_W_MAX'(req_tag[k]);
    end
  end

  always_comb begin
    eligible = '0;
    for (int k = 0; k < NREQ; k++) begin
      logic busy;
      busy = 1'b0;
      for (int s = 0; s < ADDER_LAT; s++)
        if (fl_v[s] && fl_id[s] == IW'(k)) busy = 1'b1;
      eligible[k] = rstn && req_valid[k] && !busy && (!rsp_valid[k] || rsp_ready[k]);
    end
  end

  rr_arbiter #(.N(NREQ)) u_rr (
    .eligible  (eligible),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (gidx)
  );

  assign req_ready       = grant;
  assign sel             = reqs[gidx];
  assign unused_tag_bits = ^sel.tag;

  // Operands follow the winner during a grant and otherwise hold still.
  assign add_opA = (|grant) ? sel.opA : hold_opA;
  assign add_opB = (|grant) ? sel.opB : hold_opB;
  assign add_i   = (|grant) ? sel.op  : hold_op;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr      <= '0;
      fl_v     <= '0;
      fl_id    <= '0;
      fl_tag   <= '0;
      hold_opA <= '0;
      hold_opB <= '0;
      hold_op  <= instruction_type'(0);
    end else begin
      fl_v[0] <= |grant;
      if (|grant) begin
        fl_id[0]  <= gidx;
        fl_tag[0] <= sel.tag[TAG_W-1:0];
        hold_opA  <= sel.opA;
        hold_opB  <= sel.opB;
        hold_op   <= sel.op;
        ptr       <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
      end
      for (int s = 1; s < ADDER_LAT; s++) begin
        fl_v[s]   <= fl_v[s-1];
        fl_id[s]  <= fl_id[s-1];
        fl_tag[s] <= fl_tag[s-1];
      end
    end
  end

  // A capture wins over a pop so a same-edge refill keeps rsp_valid high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_tag   <= '0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (fl_v[ADDER_LAT-1] && fl_id[ADDER_LAT-1] == IW'(k)) begin
          rsp_valid[k] <= 1'b1;
          rsp_data[k]  <= add_result;
          rsp_tag[k]   <= fl_tag[ADDER_LAT-1];
        end else if (rsp_ready[k]) begin
          rsp_valid[k] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - directed and randomized checks of adder_arbiter
module tb_adder_arbiter;
  import my_pkg::*;

  localparam int NREQ  = 2;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic            [NREQ-1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
  logic            [NREQ-1:0][31:0] req_opA, req_opB, rsp_data;
  instruction_type [NREQ-1:0]       req_op;
  logic [NREQ-1:0][TAG_W-1:0]       req_tag, rsp_tag;
  logic            [31:0]           add_opA, add_opB, add_result;
  instruction_type                  add_i;

  int checks = 0;
  int errors = 0;

  adder_arbiter #(.NREQ(NREQ), .TAG_W(TAG_W)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opA(req_opA), .req_opB(req_opB), .req_op(req_op), .req_tag(req_tag),
    .add_opA(add_opA), .add_opB(add_opB), .add_i(add_i), .add_result(add_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag)
  );

  function automatic logic [31:0] ref_alu(instruction_type op, logic [31:0] a, logic [31:0] b);
    case (op)
      OP1:     return a - b;
      OP2:     return (a < b) ? 32'd1 : 32'd0;
      OP3:     return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return a + b;
    endcase
  endfunction

  // Behavioural stand-in for the registered adder (no reset, 1-cycle latency).
  always @(posedge clk) add_result <= ref_alu(add_i, add_opA, add_opB);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0;
    rsp_ready = '0;
    req_opA   = '0;
    req_opB   = '0;
    req_op    = '{default: ADD};
    req_tag   = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic set_req(int k, instruction_type op, logic [31:0] a, logic [31:0] b, logic [TAG_W-1:0] t);
    req_op[k]  = op;
    req_opA[k] = a;
    req_opB[k] = b;
    req_tag[k] = t;
  endtask

  task automatic test_reset();
    idle_inputs();
    req_valid = 2'b11;
    rstn = 1'b0;
    #12;
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b exp 00", rsp_valid); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b exp 00", req_ready); end
    checks++; if (add_opA !== 32'd0 || add_opB !== 32'd0) begin errors++; $display("FAIL reset_add_ops: got %h %h exp 0 0", add_opA, add_opB); end
    checks++; if (add_i !== ADD) begin errors++; $display("FAIL reset_add_i: got %0d exp 0", add_i); end
    checks++; if (rsp_data !== '0 || rsp_tag !== '0) begin errors++; $display("FAIL reset_rsp_regs: got %h %h exp 0 0", rsp_data, rsp_tag); end
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic test_single_op();
    apply_reset();
    set_req(0, OP1, 32'd10, 32'd3, 4'd5);
    req_valid = 2'b01;
    rsp_ready = 2'b11;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_grant: got %b exp 01", req_ready); end
    checks++; if (add_opA !== 32'd10 || add_opB !== 32'd3 || add_i !== OP1) begin errors++; $display("FAIL single_operands: got %h %h %0d exp a 3 1", add_opA, add_opB, add_i); end
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL single_early: got %b exp 00", rsp_valid); end
    checks++; if (add_opA !== 32'd10 || add_i !== OP1) begin errors++; $display("FAIL single_hold: got %h %0d exp a 1", add_opA, add_i); end
    tick();
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b01 || rsp_data[0] !== 32'd7 || rsp_tag[0] !== 4'd5) begin errors++; $display("FAIL single_rsp: got v=%b d=%0d t=%0d exp v=01 d=7 t=5", rsp_valid, rsp_data[0], rsp_tag[0]); end
    tick();
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL single_pop: got %b exp 00", rsp_valid); end
  endtask

  task automatic test_contention();
    apply_reset();
    set_req(0, ADD, 32'd1, 32'd2, 4'hA);
    set_req(1, OP3, 32'hFFFF_FFFF, 32'd0, 4'hB);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int c = 0; c < 8; c++) begin
      logic [1:0] exp_g;
      exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      checks++; if (req_ready !== exp_g) begin errors++; $display("FAIL contention_grant c%0d: got %b exp %b", c, req_ready, exp_g); end
      if (c >= 2) begin
        checks++;
        if (rsp_valid !== exp_g) begin
          errors++; $display("FAIL contention_rsp_valid c%0d: got %b exp %b", c, rsp_valid, exp_g);
        end else if (c % 2 == 0 && (rsp_data[0] !== 32'd3 || rsp_tag[0] !== 4'hA)) begin
          errors++; $display("FAIL contention_rsp0 c%0d: got %0d/%h exp 3/a", c, rsp_data[0], rsp_tag[0]);
        end else if (c % 2 == 1 && (rsp_data[1] !== 32'd1 || rsp_tag[1] !== 4'hB)) begin
          errors++; $display("FAIL contention_rsp1 c%0d: got %0d/%h exp 1/b", c, rsp_data[1], rsp_tag[1]);
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    apply_reset();
    set_req(0, ADD, 32'd5, 32'd6, 4'd1);
    req_valid = 2'b01;
    for (int c = 0; c <= 8; c++) begin
      if (c == 6) rsp_ready = 2'b01;
      @(negedge clk);
      if (c == 0 || c == 6) begin
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_grant c%0d: got %b exp 01", c, req_ready); end
      end else if (c < 6) begin
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_stall c%0d: got %b exp 00", c, req_ready); end
      end
      if (c >= 2 && c <= 6) begin
        checks++; if (rsp_valid !== 2'b01 || rsp_data[0] !== 32'd11 || rsp_tag[0] !== 4'd1) begin errors++; $display("FAIL bp_held c%0d: got v=%b d=%0d t=%0d exp v=01 d=11 t=1", c, rsp_valid, rsp_data[0], rsp_tag[0]); end
      end
      if (c == 7) begin
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL bp_popped: got %b exp 00", rsp_valid); end
      end
      if (c == 8) begin
        checks++; if (rsp_valid !== 2'b01 || rsp_data[0] !== 32'd21 || rsp_tag[0] !== 4'd2) begin errors++; $display("FAIL bp_second: got v=%b d=%0d t=%0d exp v=01 d=21 t=2", rsp_valid, rsp_data[0], rsp_tag[0]); end
      end
      tick();
      if (c == 0) set_req(0, ADD, 32'd20, 32'd1, 4'd2);
      if (c == 6) begin
        req_valid = 2'b00;
        rsp_ready = 2'b00;
      end
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    set_req(1, ADD, 32'd100, 32'd1, 4'd3);
    req_valid = 2'b10;
    for (int c = 0; c <= 7; c++) begin
      if (c == 2 || c == 6) rsp_ready = 2'b10;
      @(negedge clk);
      if (c == 0 || c == 2) begin
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL b2b_grant c%0d: got %b exp 10", c, req_ready); end
      end
      if (c == 1 || c == 3 || c == 7) begin
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL b2b_empty c%0d: got %b exp 00", c, rsp_valid); end
      end
      if (c == 2) begin
        checks++; if (rsp_valid !== 2'b10 || rsp_data[1] !== 32'd101 || rsp_tag[1] !== 4'd3) begin errors++; $display("FAIL b2b_first: got v=%b d=%0d t=%0d exp v=10 d=101 t=3", rsp_valid, rsp_data[1], rsp_tag[1]); end
      end
      if (c >= 4 && c <= 6) begin
        checks++; if (rsp_valid !== 2'b10 || rsp_data[1] !== 32'd202 || rsp_tag[1] !== 4'd4) begin errors++; $display("FAIL b2b_second c%0d: got v=%b d=%0d t=%0d exp v=10 d=202 t=4", c, rsp_valid, rsp_data[1], rsp_tag[1]); end
      end
      tick();
      if (c == 0) set_req(1, ADD, 32'd200, 32'd2, 4'd4);
      if (c == 2) req_valid = 2'b00;
      rsp_ready = 2'b00;
    end
  endtask

  task automatic test_compare_ops();
    apply_reset();
    set_req(0, OP2, 32'hFFFF_FFFF, 32'd1, 4'd1);
    set_req(1, OP3, 32'hFFFF_FFFF, 32'd1, 4'd2);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL cmp_grant0: got %b exp 01", req_ready); end
    tick();
    set_req(0, ADD, 32'hFFFF_FFFF, 32'd1, 4'd3);
    @(negedge clk);
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL cmp_grant1: got %b exp 10", req_ready); end
    tick();
    req_valid = 2'b01;
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b01 || rsp_data[0] !== 32'd0 || rsp_tag[0] !== 4'd1) begin errors++; $display("FAIL cmp_sltu: got v=%b d=%0d t=%0d exp v=01 d=0 t=1", rsp_valid, rsp_data[0], rsp_tag[0]); end
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b10 || rsp_data[1] !== 32'd1 || rsp_tag[1] !== 4'd2) begin errors++; $display("FAIL cmp_slt: got v=%b d=%0d t=%0d exp v=10 d=1 t=2", rsp_valid, rsp_data[1], rsp_tag[1]); end
    tick();
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b01 || rsp_data[0] !== 32'd0 || rsp_tag[0] !== 4'd3) begin errors++; $display("FAIL cmp_add_wrap: got v=%b d=%0d t=%0d exp v=01 d=0 t=3", rsp_valid, rsp_data[0], rsp_tag[0]); end
    tick();
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    set_req(0, ADD, 32'd1, 32'd1, 4'd7);
    req_valid = 2'b01;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL midrst_grant: got %b exp 01", req_ready); end
    tick();
    req_valid = 2'b00;
    #2;
    rstn = 1'b0;
    set_req(0, ADD, 32'd5, 32'd5, 4'd9);
    set_req(1, ADD, 32'd3, 32'd4, 4'd8);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    #1;
    checks++; if (rsp_valid !== 2'b00 || req_ready !== 2'b00) begin errors++; $display("FAIL midrst_async: got v=%b r=%b exp 00 00", rsp_valid, req_ready); end
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01 || rsp_valid !== 2'b00) begin errors++; $display("FAIL midrst_ptr: got r=%b v=%b exp 01 00", req_ready, rsp_valid); end
    tick();
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL midrst_stale: got %b exp 00", rsp_valid); end
    tick();
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b01 || rsp_data[0] !== 32'd10 || rsp_tag[0] !== 4'd9) begin errors++; $display("FAIL midrst_fresh: got v=%b d=%0d t=%0d exp v=01 d=10 t=9", rsp_valid, rsp_data[0], rsp_tag[0]); end
    idle_inputs();
    tick();
  endtask

  // Model: each requester owns at most one outstanding result; it becomes
  // visible two cycles after acceptance and leaves when consumed.
  task automatic test_random();
    logic        has     [NREQ];
    logic [31:0] e_data  [NREQ];
    logic [3:0]  e_tag   [NREQ];
    int          e_issue [NREQ];
    logic        accepted[NREQ];
    int          mptr, last_g, exp_g, grants;
    logic [31:0] last_a, last_b;
    instruction_type last_op;
    apply_reset();
    mptr = 0; last_g = -1; grants = 0;
    last_a = '0; last_b = '0; last_op = ADD;
    for (int k = 0; k < NREQ; k++) begin
      has[k] = 1'b0; accepted[k] = 1'b0; e_issue[k] = 0; e_data[k] = '0; e_tag[k] = '0;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!req_valid[k] || accepted[k]) begin
          req_valid[k] = ($urandom_range(0, 1) == 1);
          set_req(k, instruction_type'($urandom_range(0, 3)), $urandom,
                  ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom, 4'($urandom));
        end
        rsp_ready[k] = ($urandom_range(0, 2) != 0);
      end
      @(negedge clk);
      exp_g = -1;
      for (int i = NREQ - 1; i >= 0; i--) begin
        int k;
        logic buffered;
        k = (mptr + i) % NREQ;
        buffered = has[k] && (cyc >= e_issue[k] + 2);
        if (req_valid[k] && last_g != k && (!buffered || rsp_ready[k])) exp_g = k;
      end
      checks++;
      if (req_ready !== ((exp_g < 0) ? 2'b00 : 2'(1 << exp_g))) begin
        errors++; $display("FAIL rand_grant cyc%0d: got %b exp idx %0d", cyc, req_ready, exp_g);
      end
      if (exp_g >= 0) begin
        checks++;
        if (add_opA !== req_opA[exp_g] || add_opB !== req_opB[exp_g] || add_i !== req_op[exp_g]) begin
          errors++; $display("FAIL rand_issue cyc%0d: got %h %h %0d exp %h %h %0d", cyc, add_opA, add_opB, add_i, req_opA[exp_g], req_opB[exp_g], req_op[exp_g]);
        end
      end else begin
        checks++;
        if (add_opA !== last_a || add_opB !== last_b || add_i !== last_op) begin
          errors++; $display("FAIL rand_hold cyc%0d: got %h %h %0d exp %h %h %0d", cyc, add_opA, add_opB, add_i, last_a, last_b, last_op);
        end
      end
      for (int k = 0; k < NREQ; k++) begin
        logic exp_v;
        exp_v = has[k] && (cyc >= e_issue[k] + 2);
        checks++;
        if (rsp_valid[k] !== exp_v) begin
          errors++; $display("FAIL rand_rsp_valid cyc%0d req%0d: got %b exp %b", cyc, k, rsp_valid[k], exp_v);
        end else if (exp_v && (rsp_data[k] !== e_data[k] || rsp_tag[k] !== e_tag[k])) begin
          errors++; $display("FAIL rand_rsp_data cyc%0d req%0d: got %h/%h exp %h/%h", cyc, k, rsp_data[k], rsp_tag[k], e_data[k], e_tag[k]);
        end
        if (exp_v && rsp_ready[k]) has[k] = 1'b0;
        accepted[k] = (exp_g == k);
      end
      if (exp_g >= 0) begin
        has[exp_g]     = 1'b1;
        e_data[exp_g]  = ref_alu(req_op[exp_g], req_opA[exp_g], req_opB[exp_g]);
        e_tag[exp_g]   = req_tag[exp_g];
        e_issue[exp_g] = cyc;
        last_a = req_opA[exp_g]; last_b = req_opB[exp_g]; last_op = req_op[exp_g];
        mptr = (exp_g + 1) % NREQ;
        grants++;
      end
      last_g = exp_g;
      tick();
    end
    checks++; if (grants < 100) begin errors++; $display("FAIL rand_progress: got %0d grants exp >= 100", grants); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_contention();
    test_backpressure();
    test_back_to_back();
    test_compare_ops();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
